// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants, types and helpers for the seven-segment scanner
//   SSD_CTL_OFF  all-ones digit-enable pattern (all digits dark), up to 8 digits
//   ssd_code_t   digit code type for the default 4-bit code width
//   onehot_low   active-low one-hot enable for digit idx of n (digit 0 = MSB)
//   clog2        ceiling log2, minimum 1 so counters are never zero-width
package ssd_pkg;
  localparam int SSD_MAX_DIGITS = 8;
  localparam int SSD_DATA_W = 4;
  localparam logic [SSD_MAX_DIGITS-1:0] SSD_CTL_OFF = '1;
  typedef logic [SSD_DATA_W-1:0] ssd_code_t;
  function automatic logic [SSD_MAX_DIGITS-1:0] onehot_low(input int idx, input int n);
    return ~(SSD_MAX_DIGITS'(1) << (n - 1 - idx));
  endfunction
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/ssd_refresh_div.sv
// ssd_refresh_div: free-running refresh divider that counts 0..DIV-1 while enabled
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   en_i    count enable; counter holds while low
//   wrap_o  one-cycle strobe on the enabled cycle where the counter wraps
module ssd_refresh_div
  import ssd_pkg::*;
#(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic wrap_o
);
  localparam int CW = clog2(DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  assign wrap_o = en_i && cnt_q == CW'(DIV - 1);
  always_comb cnt_d = wrap_o ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/ssd_scanner.sv
// ssd_scanner: multiplexed seven-segment scan controller with frame-coherent snapshots
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          scan enable; low = display dark, timing frozen
//   digits_in   digit k in bits [k*DATA_W +: DATA_W]; digit 0 is leftmost
//   blank       bit k high = digit k dark for the frame
//   ssd         code of the currently active digit
//   ssd_ctl     active-low digit enables; digit k on bit DIGITS-1-k
//   frame_tick  one-cycle pulse after each snapshot
// Optional build macro SSD_SCANNER_LEADING_ZERO_BLANK_EN: auto-blank leading zero digits
// (the last digit is always shown).
module ssd_scanner
  import ssd_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DATA_W      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [DIGITS*DATA_W-1:0] digits_in,
  input  logic [DIGITS-1:0]        blank,
  output logic [DATA_W-1:0]        ssd,
  output logic [DIGITS-1:0]        ssd_ctl,
  output logic                     frame_tick
);
  localparam int IW = clog2(DIGITS);
  logic [IW-1:0] idx_q, idx_d;
  logic [DIGITS*DATA_W-1:0] snap_q, snap_d;
  logic [DIGITS-1:0] bsnap_q, bsnap_d, ctl_q, ctl_d, lz;
  logic [DATA_W-1:0] ssd_q, ssd_d;
  logic primed_q, primed_d, tick_q, tick_d, wrap, last, load;

  ssd_refresh_div #(.DIV(REFRESH_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (en),
    .wrap_o(wrap)
  );

`ifdef SSD_SCANNER_LEADING_ZERO_BLANK_EN
  logic run;
  // run stays high only while every digit so far is zero; last digit excluded
  always_comb begin
    lz = '0;
    run = 1'b1;
    for (int k = 0; k < DIGITS - 1; k++) begin
      run = run && digits_in[k*DATA_W +: DATA_W] == '0;
      lz[k] = run;
    end
  end
`else
  assign lz = '0;
`endif

  always_comb begin
    last = idx_q == IW'(DIGITS - 1);
    // the first enabled cycle after reset primes the snapshot immediately
    load = en && (!primed_q || (wrap && last));
    idx_d = wrap ? (last ? '0 : idx_q + IW'(1)) : idx_q;
    snap_d = load ? digits_in : snap_q;
    bsnap_d = load ? blank | lz : bsnap_q;
    primed_d = primed_q || load;
    tick_d = load;
    ssd_d = en ? snap_q[int'(idx_q)*DATA_W +: DATA_W] : ssd_q;
    ctl_d = en && !bsnap_q[idx_q] ? DIGITS'(onehot_low(int'(idx_q), DIGITS)) : DIGITS'(SSD_CTL_OFF);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx_q <= '0;
      snap_q <= '0;
      bsnap_q <= '1;
      primed_q <= 1'b0;
      tick_q <= 1'b0;
      ssd_q <= '0;
      ctl_q <= '1;
    end else begin
      idx_q <= idx_d;
      snap_q <= snap_d;
      bsnap_q <= bsnap_d;
      primed_q <= primed_d;
      tick_q <= tick_d;
      ssd_q <= ssd_d;
      ctl_q <= ctl_d;
    end

  assign ssd = ssd_q;
  assign ssd_ctl = ctl_q;
  assign frame_tick = tick_q;
endmodule
